access_initiator: RTL and testbench

ACCESS_INITIATOR -- requirements
Module: access_initiator

---
 rtl/access_initiator_pkg.sv | 27 ++
 rtl/access_initiator_cycle_counter.sv | 37 +++
 rtl/access_initiator.sv | 155 +++++++++++++++
 tb/tb_access_initiator.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/access_initiator_pkg.sv
// Shared types and defaults for the access initiator: FSM encoding, nibble width
// and the responder write-acknowledge rule.
package access_initiator_pkg;

  localparam int unsigned NibbleW           = 4;
  localparam int unsigned AuthCyclesDefault = 5;
  localparam int unsigned AckTimeoutDefault = 4;

  typedef logic [NibbleW-1:0] nibble_t;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StAuth,
    StArm,
    StStream,
    StWaitAck,
    StRelease
  } state_e;

  // The responder has taken a word once its data register and the even/odd
  // enable pair both reflect it.
  function automatic logic word_acked(nibble_t din, logic en_left, logic en_right, nibble_t word);
    return (din == word) && (en_left == ~word[0]) && (en_right == word[0]);
  endfunction

endpackage

// File: rtl/access_initiator_cycle_counter.sv
// Up-counter with synchronous load-to-zero that stops at a programmable last value.
// Shared by the authentication hold and the write-acknowledge timeout.
module access_initiator_cycle_counter #(
  parameter int unsigned Width = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [Width-1:0] last_i,
  output logic [Width-1:0] count_o,
  output logic             tc_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = '0;
    end else if (en_i && !tc_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == last_i);

endmodule

// File: rtl/access_initiator.sv
// Session initiator for a password-protected responder: request, authenticate,
// stream nibbles with per-word acknowledge, then release.
module access_initiator
  import access_initiator_pkg::*;
#(
  parameter int unsigned AUTH_CYCLES = AuthCyclesDefault,
  parameter int unsigned ACK_TIMEOUT = AckTimeoutDefault
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [NibbleW-1:0] password_i,
  input  logic [NibbleW-1:0] data_in_i,
  input  logic               data_valid_i,
  input  logic               data_last_i,
  input  logic [NibbleW-1:0] din_obs_i,
  input  logic               en_left_obs_i,
  input  logic               en_right_obs_i,
  output logic               request_o,
  output logic               confirm_o,
  output logic [NibbleW-1:0] pass_data_o,
  output logic               data_ready_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               error_o
);

  localparam int unsigned MaxCnt = (AUTH_CYCLES > ACK_TIMEOUT) ? AUTH_CYCLES : ACK_TIMEOUT;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  state_e          state_q, state_d;
  nibble_t         pw_q, pw_d;
  nibble_t         word_q, word_d;
  logic            last_q, last_d;
  logic            error_q, error_d;
  logic            request_q, request_d;
  logic            confirm_q, confirm_d;
  nibble_t         pass_data_q, pass_data_d;
  logic            data_ready_q, data_ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            cnt_load, cnt_en, cnt_tc;
  logic [CntW-1:0] cnt_last, cnt;
  logic            ack;

  // Zeroed in the cycle before each counted state so the count starts on entry.
  assign cnt_load = (state_q == StReq) || (state_q == StStream);
  assign cnt_en   = (state_q == StAuth) || (state_q == StWaitAck);
  assign cnt_last = (state_q == StAuth) ? CntW'(AUTH_CYCLES - 1) : CntW'(ACK_TIMEOUT - 1);
  assign ack      = word_acked(din_obs_i, en_left_obs_i, en_right_obs_i, word_q);

  access_initiator_cycle_counter #(
    .Width(CntW)
  ) u_cycle_counter (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .load_i (cnt_load),
    .en_i   (cnt_en),
    .last_i (cnt_last),
    .count_o(cnt),
    .tc_o   (cnt_tc)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      pw_q         <= '0;
      word_q       <= '0;
      last_q       <= 1'b0;
      error_q      <= 1'b0;
      request_q    <= 1'b0;
      confirm_q    <= 1'b0;
      pass_data_q  <= '0;
      data_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pw_q         <= pw_d;
      word_q       <= word_d;
      last_q       <= last_d;
      error_q      <= error_d;
      request_q    <= request_d;
      confirm_q    <= confirm_d;
      pass_data_q  <= pass_data_d;
      data_ready_q <= data_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pw_d    = pw_q;
    word_d  = word_q;
    last_d  = last_q;
    error_d = error_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          pw_d    = password_i;
          error_d = 1'b0;
          state_d = StReq;
        end
      end
      StReq:  state_d = StAuth;
      StAuth: if (cnt_tc) state_d = StArm;
      StArm:  state_d = StStream;
      StStream: begin
        if (data_valid_i && data_ready_q) begin
          word_d  = data_in_i;
          last_d  = data_last_i;
          state_d = StWaitAck;
        end
      end
      StWaitAck: begin
        // The first cycle is ignored: the responder has not yet sampled the word.
        if ((cnt != '0) && ack) begin
          state_d = last_q ? StRelease : StStream;
        end else if (cnt_tc) begin
          error_d = 1'b1;
          state_d = StRelease;
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    request_d    = state_d inside {StReq, StAuth, StArm, StStream, StWaitAck};
    confirm_d    = state_d inside {StAuth, StArm};
    data_ready_d = (state_d == StStream);
    busy_d       = (state_d != StIdle);
    done_d       = (state_q == StRelease);
    pass_data_d  = pass_data_q;
    if (state_d == StAuth) begin
      pass_data_d = pw_d;
    end else if ((state_d == StWaitAck) && (state_q == StStream)) begin
      pass_data_d = word_d;
    end else if (state_d == StRelease) begin
      pass_data_d = '0;
    end
  end

  assign request_o    = request_q;
  assign confirm_o    = confirm_q;
  assign pass_data_o  = pass_data_q;
  assign data_ready_o = data_ready_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;

endmodule

// File: tb/tb_access_initiator.sv
// Bench for access_initiator: behavioural falling-edge responder, directed scenarios
// and randomized sessions checked against per-session cycle/result predictions.
module tb_access_initiator;

  localparam int unsigned AuthCycles = 5;
  localparam int unsigned AckTimeout = 4;
  localparam logic [3:0]  GoodPw     = 4'b0101;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] password = '0;
  logic [3:0] data_in = '0;
  logic       data_valid = 1'b0;
  logic       data_last = 1'b0;
  logic [3:0] din_obs;
  logic       en_left_obs, en_right_obs;
  logic       request, confirm, data_ready, busy, done, error;
  logic [3:0] pass_data;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] wq[$];
  int         gq[$];

  always #5 clk = ~clk;

  access_initiator #(
    .AUTH_CYCLES(AuthCycles),
    .ACK_TIMEOUT(AckTimeout)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .start_i       (start),
    .password_i    (password),
    .data_in_i     (data_in),
    .data_valid_i  (data_valid),
    .data_last_i   (data_last),
    .din_obs_i     (din_obs),
    .en_left_obs_i (en_left_obs),
    .en_right_obs_i(en_right_obs),
    .request_o     (request),
    .confirm_o     (confirm),
    .pass_data_o   (pass_data),
    .data_ready_o  (data_ready),
    .busy_o        (busy),
    .done_o        (done),
    .error_o       (error)
  );

  // Responder: 0 wait confirm, 1 authenticating, 2 armed (writes), 3 trapped.
  int rsp_phase = 0;
  int rsp_auth  = 0;

  always @(negedge clk) begin
    if (reset || !request) begin
      rsp_phase <= 0;
      rsp_auth  <= 0;
      if (reset) begin
        din_obs      <= '0;
        en_left_obs  <= 1'b0;
        en_right_obs <= 1'b0;
      end
    end else begin
      case (rsp_phase)
        0: if (confirm) begin
          rsp_phase <= 1;
          rsp_auth  <= (pass_data == GoodPw) ? 1 : 0;
        end
        1: begin
          if (confirm) begin
            rsp_auth <= rsp_auth + ((pass_data == GoodPw) ? 1 : 0);
          end else if (rsp_auth >= int'(AuthCycles)) begin
            rsp_phase <= 2;
          end else begin
            rsp_phase    <= 3;
            din_obs      <= '0;
            en_left_obs  <= 1'b0;
            en_right_obs <= 1'b0;
          end
        end
        2: if (!confirm) begin
          din_obs      <= pass_data;
          en_left_obs  <= ~pass_data[0];
          en_right_obs <= pass_data[0];
        end
        default: ;
      endcase
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Runs one session using wq (words) and gq (idle STREAM cycles before each word).
  // With abort set, reset is asserted in the first WAIT_ACK and left high on return.
  task automatic run_session(input logic [3:0] pw, input bit abort, input bit poke);
    bit         ok;
    int         exp_req, req_cyc, conf_cyc, done_busy, idx, gap_left, cyc;
    bit         rdy_prev;
    logic [3:0] lastw;
    ok      = (pw == GoodPw);
    exp_req = 1 + AuthCycles + 1;
    if (ok) begin
      foreach (wq[i]) exp_req += gq[i] + 1 + 2;
    end else begin
      exp_req += gq[0] + 1 + AckTimeout;
    end
    lastw = wq[wq.size() - 1];

    @(negedge clk);
    start    = 1'b1;
    password = pw;
    @(negedge clk);
    start    = 1'b0;
    password = 4'($urandom);
    check_eq("req_entry", {busy, request, confirm, data_ready, error}, 5'b11000);

    req_cyc   = 0;
    conf_cyc  = 0;
    done_busy = 0;
    idx       = 0;
    gap_left  = gq[0];
    rdy_prev  = 1'b0;
    for (cyc = 0; cyc < 400; cyc++) begin
      if (!busy) break;
      req_cyc   += int'(request);
      conf_cyc  += int'(confirm);
      done_busy += int'(done);
      if (data_valid && rdy_prev) begin
        idx++;
        if (idx < wq.size()) gap_left = gq[idx];
      end
      rdy_prev = data_ready;
      if (abort && request && !confirm && !data_ready && idx > 0) begin
        reset = 1'b1;
        #1;
        check_eq("reset_outs", {request, confirm, data_ready, busy, done, error, pass_data},
                 10'd0);
        data_valid = 1'b0;
        return;
      end
      start = poke && confirm && ($urandom_range(0, 1) == 1);
      if (data_ready && idx < wq.size()) begin
        if (gap_left > 0) begin
          gap_left--;
          data_valid = 1'b0;
          data_in    = 4'($urandom);
        end else begin
          data_valid = 1'b1;
          data_in    = wq[idx];
          data_last  = (idx == wq.size() - 1);
        end
      end else begin
        // Not in STREAM: junk that must be ignored.
        data_valid = 1'($urandom);
        data_in    = 4'($urandom);
        data_last  = 1'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    check_eq("session_bound", int'(cyc < 400), 1);
    check_eq("done_pulse", done, 1'b1);
    check_eq("done_while_busy", done_busy, 0);
    check_eq("request_cycles", req_cyc, exp_req);
    check_eq("confirm_cycles", conf_cyc, AuthCycles + 1);
    check_eq("error_flag", error, !ok);
    check_eq("idle_outs", {request, confirm, data_ready, pass_data}, 7'd0);
    if (ok) begin
      check_eq("din_obs", {din_obs, en_left_obs, en_right_obs}, {lastw, ~lastw[0], lastw[0]});
    end else begin
      check_eq("din_trap", {din_obs, en_left_obs, en_right_obs}, 6'd0);
    end
  endtask

  logic [3:0] rpw;
  int         nw;
  bit         rab;

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_state", {request, confirm, data_ready, busy, done, error, pass_data}, 10'd0);
    reset = 1'b0;

    wq = '{4'h3, 4'h8};  gq = '{0, 0};  run_session(GoodPw, 1'b0, 1'b0);
    wq = '{4'h3, 4'h8};  gq = '{1, 0};  run_session(4'b1111, 1'b0, 1'b0);
    wq = '{4'h6};        gq = '{0};     run_session(GoodPw, 1'b0, 1'b0);
    wq = '{4'h1, 4'h2};  gq = '{2, 0};  run_session(GoodPw, 1'b0, 1'b1);
    wq = '{4'hA};        gq = '{10};    run_session(GoodPw, 1'b0, 1'b0);
    wq = '{4'h7, 4'h9};  gq = '{0, 0};  run_session(GoodPw, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wq = '{4'h4};        gq = '{0};     run_session(GoodPw, 1'b0, 1'b0);

    for (int s = 0; s < 40; s++) begin
      nw = $urandom_range(1, 4);
      wq.delete();
      gq.delete();
      for (int i = 0; i < nw; i++) begin
        wq.push_back(4'($urandom));
        gq.push_back($urandom_range(0, 4));
      end
      rpw = ($urandom_range(0, 3) == 0) ? 4'($urandom) : GoodPw;
      rab = ($urandom_range(0, 7) == 0);
      run_session(rpw, rab, 1'($urandom));
      if (reset) begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
